// File: rtl/dmem_responder_if.sv
// Request/response channel pair between the pipeline's data-memory port
// (master) and the memory responder (slave).
interface dmem_responder_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Stall-capable data memory: one load/store at a time, result returned
// LATENCY cycles after acceptance and held until the requester takes it.
module dmem_responder #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = DM_ADDRESS - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_W-1:0]     mem_q [0:DEPTH-1];
  logic                  mem_we_d;

  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            lane;
  logic [DATA_W-1:0]     cur_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic                  misaligned;
  logic                  illegal;
  logic                  access_err;
  logic [DATA_W-1:0]     load_val;
  logic [DATA_W-1:0]     access_rdata;
  logic [DATA_W-1:0]     merged_word;

  // Decode the captured request against the current array contents.
  always_comb begin
    word_idx    = addr_q[DM_ADDRESS-1:2];
    lane        = addr_q[1:0];
    cur_word    = mem_q[word_idx];
    sel_byte    = cur_word[{lane, 3'b000} +: 8];
    sel_half    = lane[1] ? cur_word[31:16] : cur_word[15:0];
    misaligned  = ((funct3_q[1:0] == 2'd1) && addr_q[0]) ||
                  ((funct3_q[1:0] == 2'd2) && (lane != 2'd0));
    illegal     = write_q ? (funct3_q >= 3'd3)
                          : ((funct3_q == 3'd3) || (funct3_q >= 3'd6));
    access_err  = illegal || misaligned;

    load_val = '0;
    case (funct3_q)
      3'd0:    load_val = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      3'd1:    load_val = {{(DATA_W-16){sel_half[15]}}, sel_half};
      3'd2:    load_val = cur_word;
      3'd4:    load_val = {{(DATA_W-8){1'b0}}, sel_byte};
      3'd5:    load_val = {{(DATA_W-16){1'b0}}, sel_half};
      default: load_val = '0;
    endcase
    access_rdata = (write_q || access_err) ? '0 : load_val;

    // Untouched lanes keep their old contents on partial stores.
    merged_word = cur_word;
    case (funct3_q[1:0])
      2'd0: merged_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      2'd1: begin
        if (lane[1]) merged_word[31:16] = wdata_q[15:0];
        else         merged_word[15:0]  = wdata_q[15:0];
      end
      2'd2:    merged_word = wdata_q;
      default: merged_word = cur_word;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          funct3_d = bus.req_funct3;
          cnt_d    = 4'(LATENCY - 1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          rdata_d  = access_rdata;
          err_d    = access_err;
          mem_we_d = write_q && !access_err;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // The array has no reset; a reset in BUSY forces IDLE, so no write fires.
  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[word_idx] <= merged_word;
  end

  assign bus.req_ready = (state_q == IDLE) && reset;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
